// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game and its IR command decoder.
package snake_pkg;

    // Direction encoding; the opposite of any direction is d ^ 2.
    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    // NEC command bytes sent by the remote.
    localparam logic [7:0] NEC_UP    = 8'h6A;
    localparam logic [7:0] NEC_DOWN  = 8'hEA;
    localparam logic [7:0] NEC_LEFT  = 8'h1A;
    localparam logic [7:0] NEC_RIGHT = 8'h9A;
    localparam logic [7:0] NEC_ENTER = 8'h5A;
    localparam logic [7:0] NEC_MENU  = 8'hC2;

    // 180-degree reversal of a direction.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'd2);
    endfunction

endpackage

// File: rtl/tgl_sync.sv
// Brings the per-frame toggle from the IR receiver clock into clk and flags each flip.
module tgl_sync (
    input  logic clk,
    input  logic reset,
    input  logic tgl_in,
    output logic new_frame
);

    logic       sync1;
    logic       sync2;
    logic       last_q;
    logic [1:0] prime_cnt;
    logic       primed;

    // The edge register follows the synchronizer until the two sync flops have
    // refilled after reset, so a toggle level left over from before reset is
    // absorbed instead of being mistaken for a new frame.
    assign primed    = (prime_cnt == 2'd3);
    assign new_frame = primed && (sync2 != last_q);

    // Two-flop synchronizer, edge register and post-reset priming counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            last_q    <= 1'b0;
            prime_cnt <= 2'd0;
        end else begin
            sync1  <= tgl_in;
            sync2  <= sync1;
            last_q <= sync2;
            if (!primed) begin
                prime_cnt <= prime_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/ir_cmd_decoder.sv
// Validates NEC frames, turns them into key pulses and a tick-paced direction queue.
module ir_cmd_decoder
    import snake_pkg::*;
#(
    parameter logic [7:0] ADDR = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] word,
    input  logic        frame_tgl,
    input  logic        tick,
    input  logic        flush,
    output dir_t        dir,
    output logic        dir_step,
    output logic        key_enter,
    output logic        key_menu,
    output logic        frame_err,
    output logic        q_ovf
);

    logic        new_frame;
    logic [31:0] word_q;
    logic        frame_vld;
    logic        frame_ok;
    logic [7:0]  cmd;

    logic        is_dir;
    logic        is_enter;
    logic        is_menu;
    dir_t        cmd_dir;

    dir_t        q0;
    dir_t        q1;
    logic [1:0]  q_cnt;
    dir_t        ref_dir;
    logic        accept;
    logic        pop;
    dir_t        q0_n;
    dir_t        q1_n;
    logic [1:0]  cnt_n;
    dir_t        dir_n;
    logic        step_n;
    logic        ovf_n;

    tgl_sync u_tgl_sync (
        .clk       (clk),
        .reset     (reset),
        .tgl_in    (frame_tgl),
        .new_frame (new_frame)
    );

    // Word is stable long before the toggle arrives, so one capture on the detect cycle is safe.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q    <= 32'd0;
            frame_vld <= 1'b0;
        end else begin
            frame_vld <= new_frame;
            if (new_frame) begin
                word_q <= word;
            end
        end
    end

    assign cmd      = word_q[15:8];
    assign frame_ok = (word_q[31:24] == ADDR) &&
                      (word_q[23:16] == ~word_q[31:24]) &&
                      (word_q[7:0]   == ~word_q[15:8]);

    // Classify the command byte of a captured, valid frame; unknown codes fall through.
    always_comb begin
        is_dir   = 1'b0;
        is_enter = 1'b0;
        is_menu  = 1'b0;
        cmd_dir  = RIGHT;
        if (frame_vld && frame_ok) begin
            case (cmd)
                NEC_UP:    begin is_dir = 1'b1; cmd_dir = UP;    end
                NEC_DOWN:  begin is_dir = 1'b1; cmd_dir = DOWN;  end
                NEC_LEFT:  begin is_dir = 1'b1; cmd_dir = LEFT;  end
                NEC_RIGHT: begin is_dir = 1'b1; cmd_dir = RIGHT; end
                NEC_ENTER: is_enter = 1'b1;
                NEC_MENU:  is_menu  = 1'b1;
                default:   ;
            endcase
        end
    end

    // Queue update: reversal check against the pre-pop tail, pop then push, flush wins.
    always_comb begin
        ref_dir = dir;
        if (q_cnt == 2'd2) begin
            ref_dir = q1;
        end else if (q_cnt == 2'd1) begin
            ref_dir = q0;
        end
        accept = is_dir && (cmd_dir != ref_dir) && (cmd_dir != opposite(ref_dir));
        pop    = tick && (q_cnt != 2'd0);

        q0_n   = q0;
        q1_n   = q1;
        cnt_n  = q_cnt;
        dir_n  = dir;
        step_n = 1'b0;
        ovf_n  = 1'b0;

        if (pop) begin
            dir_n  = q0;
            step_n = 1'b1;
            q0_n   = q1;
            cnt_n  = q_cnt - 2'd1;
        end

        if (accept) begin
            if (cnt_n == 2'd2) begin
                ovf_n = 1'b1;
            end else begin
                if (cnt_n == 2'd0) begin
                    q0_n = cmd_dir;
                end else begin
                    q1_n = cmd_dir;
                end
                cnt_n = cnt_n + 2'd1;
            end
        end

        if (flush) begin
            cnt_n  = 2'd0;
            dir_n  = RIGHT;
            step_n = 1'b0;
            ovf_n  = 1'b0;
        end
    end

    // Commit queue, direction and all single-cycle output pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            q0        <= RIGHT;
            q1        <= RIGHT;
            q_cnt     <= 2'd0;
            dir       <= RIGHT;
            dir_step  <= 1'b0;
            q_ovf     <= 1'b0;
            key_enter <= 1'b0;
            key_menu  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            q0        <= q0_n;
            q1        <= q1_n;
            q_cnt     <= cnt_n;
            dir       <= dir_n;
            dir_step  <= step_n;
            q_ovf     <= ovf_n;
            key_enter <= is_enter;
            key_menu  <= is_menu;
            frame_err <= frame_vld && !frame_ok;
        end
    end

endmodule
